uart_tx_fifo_drain: RTL

Read-side consumer of the asynchronous FIFO: sits in the read clock domain, pops one word whenever the FIFO is non-empty, and serialises it onto a UART TX line (8N1 by default). Together with the FIFO it forms the outbound path that returns DDR read data to the host over UART. It handles the FIFO's one-cycle registered read latency and paces pops so the FIFO drains no faster than the line rate.

---
 rtl/uart_tx_fifo_drain.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops one word from an async FIFO read port and
// serialises it as an 8N1 UART frame (optionally 8E1).
//
// Ports:
//   rclk, rrst      read-domain clock, async active-high reset
//   fifo_data       FIFO data_out, valid the cycle after fifo_r_en
//   fifo_empty      FIFO empty flag, sampled only in IDLE
//   fifo_r_en       registered one-cycle pop request
//   tx              UART line, idle high
//   busy            high from pop request through end of stop bit
//   frame_done      one-cycle pulse in the last cycle of the stop bit
//
// Macro UART_TX_PARITY_EN: inserts an even-parity bit after the data.

module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  ren_q, ren_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic baud_end;

    assign baud_end  = (baud_q == BAUD_LAST);
    assign fifo_r_en = ren_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        ren_d      = 1'b0;
        busy_d     = busy_q;
        frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = S_RD;
                    ren_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            // FIFO registers the word on the edge that ends this state.
            S_RD: state_d = S_CAP;
            S_CAP: begin
                shreg_d = fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end
            // tx is registered, so the next bit is loaded on the
            // terminal count of the current one.
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d     = '0;
                    frame_done = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            ren_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            ren_q    <= ren_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
